debounce_edge_detect: RTL and testbench

Conditions a raw asynchronous 1-bit input, such as a pushbutton or switch, into a clean, synchronous level plus single-cycle edge pulses.
- Sits directly upstream of the rising-edge D flip-flop stage: q drives that stage's D input, and rise/fall serve as its enables or as event strobes.
- Contains a synchronizer, a stability counter and a 4-state FSM.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_edge_detect_sync_chain.sv | 37 +++
 rtl/debounce_edge_detect.sv | 132 +++++++++++++
 tb/tb_debounce_edge_detect.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and limits for the debounce/edge-detect block.
//   state_t            - 2-bit FSM state encoding used by debounce_edge_detect
//   MIN_STABLE_CYCLES  - smallest legal stability window
//   MIN_SYNC_STAGES    - smallest legal synchronizer depth
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int MIN_STABLE_CYCLES = 2;
  localparam int MIN_SYNC_STAGES   = 2;

endpackage

// File: rtl/debounce_edge_detect_sync_chain.sv
// sync_chain: multi-flop synchronizer that brings an asynchronous 1-bit
// input into the clk domain.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, loads RESET_VAL into every stage
//   din  - asynchronous input
//   dout - synchronized output (last stage)
module sync_chain
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("sync_chain: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  logic [SYNC_STAGES-1:0] sync_p;

  // Stage boundary: shift din through SYNC_STAGES flops, bit 0 is the first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: turns a raw asynchronous 1-bit input (button, switch)
// into a clean synchronous level plus single-cycle rise/fall strobes.
// A new level is accepted only after STABLE_CYCLES consecutive identical
// synchronized samples taken on enabled cycles.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   din_raw - raw asynchronous input
//   en      - sample enable; 0 freezes FSM, counter and q
//   q       - debounced level
//   rise    - one-cycle pulse when a 0->1 change is accepted
//   fall    - one-cycle pulse when a 1->0 change is accepted
//   busy    - high while a candidate change is being qualified
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_stable_cycles
    $error("debounce_edge_detect: STABLE_CYCLES must be at least %0d",
           MIN_STABLE_CYCLES);
  end

  localparam int             CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam state_t         RST_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

  logic           s;
  state_t         state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic           q_d, rise_d, fall_d;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (din_raw),
    .dout (s)
  );

  // Next-state logic. Pulses default low so a pending strobe always clears on
  // the following edge, even when en is low. The first differing sample
  // already counts as one, so the WAIT state starts at cnt=1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    q_d     = q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      unique case (state)
        STABLE_LO: begin
          if (s) begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt == CNT_MAX) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            q_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt == CNT_MAX) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            q_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        default: begin
          state_d = RST_STATE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage boundary: FSM, counter, level and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
      q     <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      q     <= q_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect with default parameters.
module tb_debounce_edge_detect;
  import debounce_pkg::*;

  logic clk;
  logic rst;
  logic din_raw;
  logic en;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  int npass  = 0;
  int ntotal = 0;
  int n_rise = 0;
  int n_fall = 0;
  int n_both = 0;
  int base_r;
  int base_f;

  debounce_edge_detect #(
    .STABLE_CYCLES (16),
    .SYNC_STAGES   (2),
    .RESET_VAL     (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din_raw (din_raw),
    .en      (en),
    .q       (q),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle: one count per high cycle.
  always @(negedge clk) begin
    if (rise) n_rise++;
    if (fall) n_fall++;
    if (rise && fall) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // din_raw has just been set to its new, held value; the next edge is E0.
  // Checks every cycle from E0 through E0+18.
  task automatic watch(input logic up, input string tag);
    for (int k = 0; k <= 18; k++) begin
      tick();
      chk({tag, "_busy"}, busy, (k >= 2 && k <= 16));
      chk({tag, "_q"},    q,    up ? (k >= 17) : (k < 17));
      chk({tag, "_rise"}, rise, up && (k == 17));
      chk({tag, "_fall"}, fall, !up && (k == 17));
    end
  endtask

  initial begin
    rst     = 1'b1;
    din_raw = 1'b1;
    en      = 1'b1;

    // 1. Reset with din_raw high, then release.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_q", q, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    chk("rst_state", 32'(dut.state), 32'(STABLE_LO));
    chk("rst_cnt", 32'(dut.cnt), 0);
    base_r = n_rise;
    base_f = n_fall;
    rst = 1'b0;
    watch(1'b1, "release");
    chk("release_nrise", n_rise - base_r, 1);
    chk("release_nfall", n_fall - base_f, 0);

    // 2. Clean steps in both directions.
    din_raw = 1'b0;
    watch(1'b0, "step_fall");
    din_raw = 1'b1;
    watch(1'b1, "step_rise");
    din_raw = 1'b0;
    watch(1'b0, "step_fall2");

    // 3. Glitch of 10 cycles is rejected.
    base_r = n_rise;
    din_raw = 1'b1;
    repeat (10) tick();
    chk("glitch_busy_mid", busy, 1'b1);
    din_raw = 1'b0;
    tick();
    tick();
    chk("glitch_busy_e11", busy, 1'b1);
    tick();
    chk("glitch_busy_e12", busy, 1'b0);
    chk("glitch_state", 32'(dut.state), 32'(STABLE_LO));
    chk("glitch_cnt", 32'(dut.cnt), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("glitch_q", q, 1'b0);
    end
    chk("glitch_nrise", n_rise - base_r, 0);

    // 4. Bounce: toggle every 3 cycles for 30 cycles, then settle high.
    base_r = n_rise;
    for (int seg = 0; seg < 10; seg++) begin
      din_raw = (seg % 2 == 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("bounce_q", q, 1'b0);
      end
    end
    din_raw = 1'b1;
    watch(1'b1, "bounce_settle");
    chk("bounce_nrise", n_rise - base_r, 1);

    // 5. Enable stall of 20 edges once cnt reaches 8.
    din_raw = 1'b0;
    watch(1'b0, "pre_stall");
    base_r = n_rise;
    din_raw = 1'b1;
    repeat (10) tick();
    chk("stall_cnt_before", 32'(dut.cnt), 8);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_q", q, 1'b0);
      chk("stall_rise", rise, 1'b0);
      chk("stall_busy", busy, 1'b1);
    end
    chk("stall_cnt_held", 32'(dut.cnt), 8);
    en = 1'b1;
    repeat (7) tick();
    chk("stall_q_e36", q, 1'b0);
    chk("stall_busy_e36", busy, 1'b1);
    tick();
    chk("stall_q_e37", q, 1'b1);
    chk("stall_rise_e37", rise, 1'b1);
    tick();
    chk("stall_rise_e38", rise, 1'b0);
    chk("stall_nrise", n_rise - base_r, 1);

    // 6. Reset in the middle of qualification.
    din_raw = 1'b0;
    watch(1'b0, "pre_rst");
    base_r = n_rise;
    din_raw = 1'b1;
    repeat (10) tick();
    chk("midrst_cnt_before", 32'(dut.cnt), 8);
    rst = 1'b1;
    tick();
    chk("midrst_state", 32'(dut.state), 32'(STABLE_LO));
    chk("midrst_cnt", 32'(dut.cnt), 0);
    chk("midrst_q", q, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rise", rise, 1'b0);
    rst = 1'b0;
    watch(1'b1, "after_rst");
    chk("midrst_nrise", n_rise - base_r, 1);

    chk("never_both", n_both, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
